// File: rtl/clint_bus_arbiter.sv
// Round-robin arbiter in front of the single CLINT register port.
// Each access runs IDLE -> BUSY -> DONE. The one-cycle DONE state absorbs the
// slave's registered ready, which is still high from the last BUSY cycle.
// Optional feature: define CLINT_ARB_TIMEOUT_EN to bound the BUSY wait at
// TIMEOUT_CYCLES. On expiry the access completes with req_err=1 and zero data.
module clint_bus_arbiter #(
    parameter int unsigned NUM_REQ        = 2,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [NUM_REQ-1:0]    req_valid,
    input  logic [NUM_REQ*24-1:0] req_addr,
    input  logic [NUM_REQ*4-1:0]  req_wmask,
    input  logic [NUM_REQ*32-1:0] req_wdata,
    output logic [NUM_REQ-1:0]    req_ready,
    output logic [31:0]           req_rdata,
    output logic                  req_err,
    output logic                  clint_valid,
    output logic [23:0]           clint_addr,
    output logic [3:0]            clint_wmask,
    output logic [31:0]           clint_wdata,
    input  logic [31:0]           clint_rdata,
    input  logic                  clint_ready
);

    localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        StIdle,
        StBusy,
        StDone
    } state_e;

    state_e              state;
    logic [IdxW-1:0]     grant;
    logic [IdxW-1:0]     rr_ptr;
    logic [IdxW-1:0]     grant_next_ptr;
    logic [NUM_REQ-1:0]  grant_onehot;

    logic                any_valid;
    logic [IdxW-1:0]     winner;

    logic [23:0]         addr_arr  [NUM_REQ];
    logic [3:0]          wmask_arr [NUM_REQ];
    logic [31:0]         wdata_arr [NUM_REQ];

`ifdef CLINT_ARB_TIMEOUT_EN
    localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TmoW-1:0]     tmo_cnt;
    logic                tmo_hit;

    // The counter would reach TIMEOUT_CYCLES at the end of this BUSY cycle.
    assign tmo_hit = ((32'(tmo_cnt) + 32'd1) >= TIMEOUT_CYCLES);
`else
    logic                unused_timeout;

    assign unused_timeout = ^TIMEOUT_CYCLES;
    assign req_err        = 1'b0;
`endif

    // Winner search: first set request at or above rr_ptr, else first below it.
    always_comb begin
        any_valid = 1'b0;
        winner    = rr_ptr;
        for (int j = 0; j < int'(NUM_REQ); j++) begin
            if (!any_valid && req_valid[j] && (j >= int'(rr_ptr))) begin
                any_valid = 1'b1;
                winner    = j[IdxW-1:0];
            end
        end
        for (int j = 0; j < int'(NUM_REQ); j++) begin
            if (!any_valid && req_valid[j]) begin
                any_valid = 1'b1;
                winner    = j[IdxW-1:0];
            end
        end
    end

    // Unpack the flat request buses so the slave mux is a plain array select.
    always_comb begin
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            addr_arr[i]  = req_addr[24*i +: 24];
            wmask_arr[i] = req_wmask[4*i +: 4];
            wdata_arr[i] = req_wdata[32*i +: 32];
        end
    end

    // Slave-side request: valid only in BUSY, fields follow the current grant.
    always_comb begin
        clint_valid = (state == StBusy);
        clint_addr  = addr_arr[grant];
        clint_wmask = wmask_arr[grant];
        clint_wdata = wdata_arr[grant];
    end

    // Pointer after the current grant completes, and the grant as a one-hot pulse.
    always_comb begin
        if (32'(grant) == NUM_REQ - 1) begin
            grant_next_ptr = '0;
        end else begin
            grant_next_ptr = grant + 1'b1;
        end
        grant_onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << grant;
    end

    // Access sequencer with registered completion outputs.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state     <= StIdle;
            grant     <= '0;
            rr_ptr    <= '0;
            req_ready <= '0;
            req_rdata <= '0;
`ifdef CLINT_ARB_TIMEOUT_EN
            req_err   <= 1'b0;
            tmo_cnt   <= '0;
`endif
        end else begin
            case (state)
                StIdle: begin
                    req_ready <= '0;
`ifdef CLINT_ARB_TIMEOUT_EN
                    req_err   <= 1'b0;
`endif
                    if (any_valid) begin
                        grant <= winner;
                        state <= StBusy;
`ifdef CLINT_ARB_TIMEOUT_EN
                        tmo_cnt <= '0;
`endif
                    end
                end
                StBusy: begin
                    if (clint_ready) begin
                        req_rdata <= clint_rdata;
                        req_ready <= grant_onehot;
                        rr_ptr    <= grant_next_ptr;
                        state     <= StDone;
`ifdef CLINT_ARB_TIMEOUT_EN
                    end else if (tmo_hit) begin
                        // Unmapped address or dead slave: complete with an error.
                        req_rdata <= 32'h0000_0000;
                        req_ready <= grant_onehot;
                        req_err   <= 1'b1;
                        rr_ptr    <= grant_next_ptr;
                        state     <= StDone;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
`endif
                    end
                end
                StDone: begin
                    // clint_ready is still high from the last BUSY cycle; ignore it.
                    req_ready <= '0;
`ifdef CLINT_ARB_TIMEOUT_EN
                    req_err   <= 1'b0;
`endif
                    state     <= StIdle;
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_clint_bus_arbiter.sv
// Directed bench for clint_bus_arbiter with NUM_REQ=2 and a small registered-ready
// slave model. Define CLINT_ARB_TIMEOUT_EN for both files to cover the timeout path.
module tb_clint_bus_arbiter;

    logic        clk = 1'b0;
    logic        resetn;
    logic [1:0]  req_valid;
    logic [47:0] req_addr;
    logic [7:0]  req_wmask;
    logic [63:0] req_wdata;
    logic [1:0]  req_ready;
    logic [31:0] req_rdata;
    logic        req_err;
    logic        clint_valid;
    logic [23:0] clint_addr;
    logic [3:0]  clint_wmask;
    logic [31:0] clint_wdata;
    logic [31:0] clint_rdata;
    logic        clint_ready = 1'b0;

    logic        slv_valid_d = 1'b0;
    logic        stale_mode;
    logic        slave_mute;

    int checks   = 0;
    int failures = 0;
    int cnt;
    int exp_idx;

    always #5 clk = ~clk;

    clint_bus_arbiter #(
        .NUM_REQ        (2),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .req_valid   (req_valid),
        .req_addr    (req_addr),
        .req_wmask   (req_wmask),
        .req_wdata   (req_wdata),
        .req_ready   (req_ready),
        .req_rdata   (req_rdata),
        .req_err     (req_err),
        .clint_valid (clint_valid),
        .clint_addr  (clint_addr),
        .clint_wmask (clint_wmask),
        .clint_wdata (clint_wdata),
        .clint_rdata (clint_rdata),
        .clint_ready (clint_ready)
    );

    // Slave: ready the cycle after a valid; optionally one extra stale cycle.
    always @(posedge clk) begin
        slv_valid_d <= clint_valid;
        clint_ready <= !slave_mute && (clint_valid || (stale_mode && slv_valid_d));
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn      = 1'b0;
        req_valid   = '0;
        req_addr    = '0;
        req_wmask   = '0;
        req_wdata   = '0;
        clint_rdata = '0;
        stale_mode  = 1'b0;
        slave_mute  = 1'b0;
        repeat (3) step();
        check("rst_clint_valid", 32'(clint_valid), 32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_req_rdata", req_rdata, 32'd0);
        check("rst_req_err", 32'(req_err), 32'd0);

        // Requester 0 read: valid cycle 1, ready pulse cycle 3.
        resetn         = 1'b1;
        req_addr[23:0] = 24'h00_bff8;
        req_wmask[3:0] = 4'h0;
        clint_rdata    = 32'h1234_5678;
        req_valid      = 2'b01;
        step();
        check("rd_c1_valid", 32'(clint_valid), 32'd1);
        check("rd_c1_addr", 32'(clint_addr), 32'h00_bff8);
        check("rd_c1_wmask", 32'(clint_wmask), 32'h0);
        check("rd_c1_ready", 32'(req_ready), 32'd0);
        step();
        check("rd_c2_valid", 32'(clint_valid), 32'd1);
        check("rd_c2_ready", 32'(req_ready), 32'd0);
        step();
        check("rd_c3_ready", 32'(req_ready), 32'b01);
        check("rd_c3_rdata", req_rdata, 32'h1234_5678);
        check("rd_c3_err", 32'(req_err), 32'd0);
        check("rd_c3_valid", 32'(clint_valid), 32'd0);
        req_valid = 2'b00;
        step();
        check("rd_c4_ready", 32'(req_ready), 32'd0);
        check("rd_c4_rdata_hold", req_rdata, 32'h1234_5678);

        // Requester 1 write; requester 0 fields differ to expose a bad mux.
        req_addr[47:24]  = 24'h00_4000;
        req_wmask[7:4]   = 4'hF;
        req_wdata[63:32] = 32'h0000_1000;
        req_addr[23:0]   = 24'hab_cdef;
        req_wmask[3:0]   = 4'h3;
        req_wdata[31:0]  = 32'h5555_aaaa;
        clint_rdata      = 32'hdead_beef;
        req_valid        = 2'b10;
        step();
        check("wr_c1_valid", 32'(clint_valid), 32'd1);
        check("wr_c1_addr", 32'(clint_addr), 32'h00_4000);
        check("wr_c1_wmask", 32'(clint_wmask), 32'hF);
        check("wr_c1_wdata", clint_wdata, 32'h0000_1000);
        step();
        check("wr_c2_ready", 32'(req_ready), 32'd0);
        step();
        check("wr_c3_ready", 32'(req_ready), 32'b10);
        req_valid = 2'b00;
        step();
        check("wr_c4_ready", 32'(req_ready), 32'd0);

        // Fairness: both requesters valid from reset, four accesses alternate.
        resetn = 1'b0;
        req_addr[23:0]  = 24'h00_0010;
        req_addr[47:24] = 24'h00_0020;
        req_wmask       = '0;
        req_valid       = 2'b11;
        repeat (2) step();
        resetn = 1'b1;
        for (int k = 0; k < 4; k++) begin
            exp_idx = k % 2;
            cnt = 0;
            while (!clint_valid && cnt < 20) begin
                step();
                cnt++;
            end
            check("rr_valid", 32'(clint_valid), 32'd1);
            check("rr_addr", 32'(clint_addr), (exp_idx == 1) ? 32'h20 : 32'h10);
            cnt = 0;
            while (req_ready == 2'b00 && cnt < 20) begin
                step();
                cnt++;
            end
            check("rr_ready", 32'(req_ready), (exp_idx == 1) ? 32'b10 : 32'b01);
            check("rr_gap_done", 32'(clint_valid), 32'd0);
            step();
            check("rr_gap_idle", 32'(clint_valid), 32'd0);
            check("rr_idle_ready", 32'(req_ready), 32'd0);
        end
        req_valid = 2'b00;
        step();

        // Move rr_ptr to 1, then reset in the middle of requester 1's access.
        req_valid = 2'b01;
        repeat (3) step();
        check("pre_rst_ready", 32'(req_ready), 32'b01);
        req_valid = 2'b00;
        step();
        req_valid = 2'b10;
        step();
        check("pre_rst_busy_addr", 32'(clint_addr), 32'h20);
        resetn = 1'b0;
        step();
        check("midrst_valid", 32'(clint_valid), 32'd0);
        check("midrst_ready", 32'(req_ready), 32'd0);
        check("midrst_rdata", req_rdata, 32'd0);
        check("midrst_err", 32'(req_err), 32'd0);
        step();
        check("midrst_ready2", 32'(req_ready), 32'd0);
        req_valid = 2'b11;
        resetn    = 1'b1;
        step();
        check("postrst_addr", 32'(clint_addr), 32'h10);
        check("postrst_ready", 32'(req_ready), 32'd0);
        repeat (2) step();
        check("postrst_done", 32'(req_ready), 32'b01);
        req_valid = 2'b00;
        step();

        // Stale ready held into IDLE must not complete anything.
        stale_mode  = 1'b1;
        clint_rdata = 32'hcafe_f00d;
        req_valid   = 2'b01;
        repeat (3) step();
        check("stale_c3_ready", 32'(req_ready), 32'b01);
        check("stale_c3_rdata", req_rdata, 32'hcafe_f00d);
        req_valid = 2'b10;
        step();
        check("stale_c4_ready", 32'(req_ready), 32'd0);
        step();
        check("stale_c5_valid", 32'(clint_valid), 32'd1);
        check("stale_c5_ready", 32'(req_ready), 32'd0);
        step();
        check("stale_c6_ready", 32'(req_ready), 32'd0);
        step();
        check("stale_c7_ready", 32'(req_ready), 32'b10);
        req_valid = 2'b00;
        step();
        check("stale_c8_ready", 32'(req_ready), 32'd0);
        step();
        check("stale_c9_ready", 32'(req_ready), 32'd0);
        stale_mode = 1'b0;

`ifdef CLINT_ARB_TIMEOUT_EN
        // Slave never answers: completion with error after 16 BUSY cycles.
        slave_mute     = 1'b1;
        req_addr[23:0] = 24'h00_1234;
        req_valid      = 2'b01;
        repeat (16) step();
        check("tmo_c16_valid", 32'(clint_valid), 32'd1);
        check("tmo_c16_ready", 32'(req_ready), 32'd0);
        step();
        check("tmo_ready", 32'(req_ready), 32'b01);
        check("tmo_err", 32'(req_err), 32'd1);
        check("tmo_rdata", req_rdata, 32'd0);
        req_valid  = 2'b00;
        slave_mute = 1'b0;
        step();
        check("tmo_idle_err", 32'(req_err), 32'd0);
        clint_rdata = 32'h1111_2222;
        req_valid   = 2'b10;
        repeat (3) step();
        check("tmo_next_ready", 32'(req_ready), 32'b10);
        check("tmo_next_err", 32'(req_err), 32'd0);
        check("tmo_next_rdata", req_rdata, 32'h1111_2222);
        req_valid = 2'b00;
        step();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/clint_bus_arbiter.md
Name: clint_bus_arbiter

Overview:
- Round-robin arbiter sharing the single CLINT register port (msip/mtimecmp/mtime) among NUM_REQ bus masters, e.g. hart data port plus a debug/boot master.
- Sits between the requesters' valid/ready interfaces and the CLINT slave.
- Sequences each access: grant, hold the slave's valid until its registered ready, return the read data, then one recovery cycle so the slave's stale ready is never misattributed.

Parameters:
- NUM_REQ, 2, number of requesters; legal range 2..8.
- TIMEOUT_CYCLES, 16, slave-response timeout in clk cycles; used only with CLINT_ARB_TIMEOUT_EN.

Ports:
- clk  input  1  system clock
- resetn  input  1  reset, synchronous, active-low
- req_valid  input  NUM_REQ  per-requester access request
- req_addr  input  NUM_REQ*24  per-requester address, requester i at [24*i+23:24*i]
- req_wmask  input  NUM_REQ*4  per-requester byte write mask; 0 means read
- req_wdata  input  NUM_REQ*32  per-requester write data
- req_ready  output  NUM_REQ  one-cycle completion pulse to the granted requester
- req_rdata  output  32  read data, shared, valid while any req_ready bit is high
- req_err  output  1  timeout pulse, coincident with req_ready; tied 0 when feature is off
- clint_valid  output  1  slave request
- clint_addr  output  24  slave address
- clint_wmask  output  4  slave write mask
- clint_wdata  output  32  slave write data
- clint_rdata  input  32  slave read data (combinational)
- clint_ready  input  1  slave ready, registered: high the cycle after the slave sees a valid, mapped access

Behaviour:
- Reset (resetn=0 at posedge): state=IDLE, grant=0, rr_ptr=0, req_ready=0, req_rdata=0, req_err=0, clint_valid=0, timeout counter=0.
  - Reset mid-access aborts the access.
  - No req_ready is issued for the aborted access.
- Requester rule: hold valid/addr/wmask/wdata stable until its req_ready pulse, then drop valid on the following cycle.
- IDLE:
  - If any req_valid is set, select the winner by priority search starting at rr_ptr, wrapping modulo NUM_REQ.
  - Register the winner into grant and go to BUSY.
  - clint_valid=0 in IDLE.
- BUSY:
  - clint_valid=1.
  - clint_addr, clint_wmask and clint_wdata are muxed combinationally from the req_* fields indexed by grant.
  - On clint_ready=1: register clint_rdata into req_rdata, set req_ready[grant]=1 for the next cycle, set rr_ptr=(grant+1) mod NUM_REQ, go to DONE.
- DONE (exactly 1 cycle):
  - req_ready[grant]=1 and clint_valid=0.
  - clint_ready still reads high this cycle from the earlier valid; ignore it.
  - Go to IDLE. req_ready returns to 0.
- Latency:
  - Request first seen in IDLE at cycle 0.
  - clint_valid asserted cycle 1.
  - clint_ready cycle 2.
  - req_ready/req_rdata cycle 3.
  - Next grant's clint_valid no earlier than cycle 5.
- Fairness:
  - The pointer advances only after a completed access.
  - With continuous requests from all requesters, grants rotate 0,1,...,NUM_REQ-1,0.
- Simultaneous events:
  - A request arriving while BUSY/DONE waits. It is evaluated in the next IDLE cycle.
  - A requester deasserting valid while not granted loses nothing.
- The slave commits writes every cycle clint_valid is high. The arbiter keeps clint_valid high only in BUSY, so a write is repeated at most for the BUSY cycles (same data, idempotent).
- req_rdata holds its last value outside req_ready pulses.

Optional Feature:
- Macro CLINT_ARB_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to BUSY and increments every BUSY cycle without clint_ready.
  - When it reaches TIMEOUT_CYCLES, go to DONE with req_rdata=32'h0000_0000 and req_err=1 for the DONE cycle. This covers an unmapped address, where the slave never raises ready.
  - rr_ptr advances as for a normal completion.
- Not defined:
  - No counter; BUSY waits indefinitely for clint_ready.
  - req_err is constant 0.

Test Plan:
- Reset, then requester 0 reads addr 24'h00_bff8 with clint_rdata=32'h1234_5678 -> clint_valid high cycle 1, req_ready[0] pulse cycle 3, req_rdata=32'h1234_5678, req_err=0.
- Requester 1 writes addr 24'h00_4000, wmask=4'hF, wdata=32'h0000_1000 -> clint_addr/wmask/wdata match during BUSY, single req_ready[1] pulse, req_ready[0] stays 0.
- Both requesters valid continuously from reset for 4 accesses -> grant order 0,1,0,1. clint_valid low for at least one DONE plus one IDLE cycle between accesses.
- resetn=0 asserted during BUSY, then released -> outputs return to 0, no req_ready pulse, next request granted starting from requester 0.
- (CLINT_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16) requester 0 reads addr 24'h00_1234, clint_ready held 0 -> after 16 BUSY cycles req_ready[0]=1, req_err=1, req_rdata=0. A following access from requester 1 completes normally.
- Stale-ready check: the slave model keeps clint_ready high one extra cycle after clint_valid drops -> no spurious req_ready, no double completion.
